// File: rtl/lr_d_sequencer.sv
// lr_d_sequencer: feeds the two-column leaky-ReLU-derivative datapath from a
// row-packed input stream. Column 2 is issued one cycle after column 1
// (systolic skew), and the two column results are re-joined into row-packed
// output rows.
// Optional build macro: LRD_SEQ_PERF_EN adds the stall_cycles and job_cycles
// performance counters.
module lr_d_sequencer #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [DATA_W-1:0] leak_factor_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_grad_1,
    input  logic [DATA_W-1:0] in_grad_2,
    input  logic [DATA_W-1:0] in_h_1,
    input  logic [DATA_W-1:0] in_h_2,
    output logic [DATA_W-1:0] dp_leak_factor,
    output logic              dp_valid_1,
    output logic              dp_valid_2,
    output logic [DATA_W-1:0] dp_data_1,
    output logic [DATA_W-1:0] dp_data_2,
    output logic [DATA_W-1:0] dp_h_1,
    output logic [DATA_W-1:0] dp_h_2,
    input  logic              dp_res_valid_1,
    input  logic              dp_res_valid_2,
    input  logic [DATA_W-1:0] dp_res_1,
    input  logic [DATA_W-1:0] dp_res_2,
`ifdef LRD_SEQ_PERF_EN
    output logic [15:0]       stall_cycles,
    output logic [15:0]       job_cycles,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   num_rows_q;
    logic [DATA_W-1:0]  leak_q;
    logic [ROW_W-1:0]   issued_q;
    logic [ROW_W-1:0]   received_q;

    logic               dp_valid_1_q, dp_valid_2_q;
    logic [DATA_W-1:0]  dp_data_1_q, dp_data_2_q, dp_h_1_q, dp_h_2_q;
    logic               skew_valid_q;
    logic [DATA_W-1:0]  skew_grad_q, skew_h_q;

    logic               pending_q;
    logic [DATA_W-1:0]  hold_q;
    logic               err_q;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_1_q, out_data_2_q;

    logic               start_accept;
    logic               accept;
    logic               last_accept;
    logic               deskew_en;

    // A start is only honoured from IDLE; anywhere else it is ignored.
    assign start_accept = (state_q == ST_IDLE) && start;
    assign in_ready     = (state_q == ST_FEED) && (issued_q < num_rows_q);
    assign accept       = in_valid && in_ready;
    assign last_accept  = accept && ((issued_q + ROW_W'(1)) == num_rows_q);
    assign deskew_en    = (state_q == ST_FEED) || (state_q == ST_DRAIN);

    // Next-state logic for the job FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_rows == '0) ? ST_DONE : ST_FEED;
                end
            end
            ST_FEED: begin
                if (last_accept) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (received_q == num_rows_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register, per-job configuration latch and issue counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            num_rows_q <= '0;
            leak_q     <= '0;
            issued_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_accept) begin
                num_rows_q <= num_rows;
                leak_q     <= leak_factor_in;
                issued_q   <= '0;
            end else if (accept) begin
                issued_q <= issued_q + ROW_W'(1);
            end
        end
    end

    // Issue pipeline: column 1 one cycle after accept, column 2 one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dp_valid_1_q <= 1'b0;
            dp_valid_2_q <= 1'b0;
            skew_valid_q <= 1'b0;
            dp_data_1_q  <= '0;
            dp_h_1_q     <= '0;
            dp_data_2_q  <= '0;
            dp_h_2_q     <= '0;
            skew_grad_q  <= '0;
            skew_h_q     <= '0;
        end else begin
            dp_valid_1_q <= accept;
            skew_valid_q <= accept;
            dp_valid_2_q <= skew_valid_q;
            if (accept) begin
                dp_data_1_q <= in_grad_1;
                dp_h_1_q    <= in_h_1;
                skew_grad_q <= in_grad_2;
                skew_h_q    <= in_h_2;
            end
            if (skew_valid_q) begin
                dp_data_2_q <= skew_grad_q;
                dp_h_2_q    <= skew_h_q;
            end
        end
    end

    // De-skew: park the column-1 result until its column-2 partner arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q    <= 1'b0;
            hold_q       <= '0;
            err_q        <= 1'b0;
            received_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_1_q <= '0;
            out_data_2_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (start_accept) begin
                err_q      <= 1'b0;
                received_q <= '0;
                pending_q  <= 1'b0;
            end else if (deskew_en) begin
                if (dp_res_valid_2) begin
                    if (pending_q) begin
                        out_valid_q  <= 1'b1;
                        out_data_1_q <= hold_q;
                        out_data_2_q <= dp_res_2;
                        received_q   <= received_q + ROW_W'(1);
                    end else begin
                        // Orphan column-2 result: dropped, not counted.
                        err_q <= 1'b1;
                    end
                end
                if (dp_res_valid_1) begin
                    hold_q    <= dp_res_1;
                    pending_q <= 1'b1;
                    // Second column-1 result before its partner overwrites hold.
                    if (pending_q && !dp_res_valid_2) begin
                        err_q <= 1'b1;
                    end
                end else if (dp_res_valid_2) begin
                    pending_q <= 1'b0;
                end
            end
        end
    end

`ifdef LRD_SEQ_PERF_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] job_cycles_q;

    // Performance counters: input starvation in FEED and total job length.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            job_cycles_q   <= '0;
        end else if (start_accept) begin
            stall_cycles_q <= '0;
            job_cycles_q   <= 16'd1;
        end else begin
            if (in_ready && !in_valid && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if ((state_q != ST_IDLE) && (job_cycles_q != 16'hFFFF)) begin
                job_cycles_q <= job_cycles_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign job_cycles   = job_cycles_q;
`endif

    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign err            = err_q;
    assign dp_leak_factor = leak_q;
    assign dp_valid_1     = dp_valid_1_q;
    assign dp_valid_2     = dp_valid_2_q;
    assign dp_data_1      = dp_data_1_q;
    assign dp_data_2      = dp_data_2_q;
    assign dp_h_1         = dp_h_1_q;
    assign dp_h_2         = dp_h_2_q;
    assign out_valid      = out_valid_q;
    assign out_data_1     = out_data_1_q;
    assign out_data_2     = out_data_2_q;

endmodule

// File: tb/tb_lr_d_sequencer.sv
// Directed testbench for lr_d_sequencer with a one-cycle leaky-ReLU-derivative
// datapath stand-in (Q8.8: H>0 passes grad, otherwise grad*leak>>8).
module tb_lr_d_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  num_rows;
    logic [15:0] leak_factor_in;
    logic        busy, done, err;
    logic        in_valid, in_ready;
    logic [15:0] in_grad_1, in_grad_2, in_h_1, in_h_2;
    logic [15:0] dp_leak_factor;
    logic        dp_valid_1, dp_valid_2;
    logic [15:0] dp_data_1, dp_data_2, dp_h_1, dp_h_2;
    logic        m_v1, m_v2, inj_v2, res_v2_w;
    logic [15:0] m_r1, m_r2;
    logic        out_valid;
    logic [15:0] out_data_1, out_data_2;
`ifdef LRD_SEQ_PERF_EN
    logic [15:0] stall_cycles, job_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int v1_cnt   = 0;
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    int          qc[$];

    logic [15:0] tg1[4], th1[4], tg2[4], th2[4];
    logic [15:0] e1_40[4], e2_40[4];

    assign res_v2_w = m_v2 | inj_v2;

    lr_d_sequencer #(.DATA_W(16), .ROW_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .leak_factor_in(leak_factor_in), .busy(busy), .done(done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_grad_1(in_grad_1), .in_grad_2(in_grad_2),
        .in_h_1(in_h_1), .in_h_2(in_h_2),
        .dp_leak_factor(dp_leak_factor),
        .dp_valid_1(dp_valid_1), .dp_valid_2(dp_valid_2),
        .dp_data_1(dp_data_1), .dp_data_2(dp_data_2),
        .dp_h_1(dp_h_1), .dp_h_2(dp_h_2),
        .dp_res_valid_1(m_v1), .dp_res_valid_2(res_v2_w),
        .dp_res_1(m_r1), .dp_res_2(m_r2),
`ifdef LRD_SEQ_PERF_EN
        .stall_cycles(stall_cycles), .job_cycles(job_cycles),
`endif
        .out_valid(out_valid), .out_data_1(out_data_1), .out_data_2(out_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lrd(input logic [15:0] g, input logic [15:0] h,
                                        input logic [15:0] leak);
        logic signed [31:0] gs, ls, p;
        gs = {{16{g[15]}}, g};
        ls = {{16{leak[15]}}, leak};
        p  = gs * ls;
        if (!h[15] && (h != 16'h0000)) return g;
        return p[23:8];
    endfunction

    // Datapath stand-in with one cycle of latency per column.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_v1 <= 1'b0; m_v2 <= 1'b0; m_r1 <= '0; m_r2 <= '0;
        end else begin
            m_v1 <= dp_valid_1;
            m_v2 <= dp_valid_2;
            m_r1 <= lrd(dp_data_1, dp_h_1, dp_leak_factor);
            m_r2 <= lrd(dp_data_2, dp_h_2, dp_leak_factor);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Output-row monitor: one line per emitted row.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                q1.push_back(out_data_1);
                q2.push_back(out_data_2);
                qc.push_back(cyc);
                $display("row out cyc=%0d col1=%h col2=%h", cyc, out_data_1, out_data_2);
            end
            if (done) done_cnt++;
            if (dp_valid_1) v1_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_row(input int k);
        in_grad_1 = tg1[k]; in_h_1 = th1[k];
        in_grad_2 = tg2[k]; in_h_2 = th2[k];
    endtask

    task automatic start_job(input logic [7:0] n, input logic [15:0] leak);
        start = 1'b1; num_rows = n; leak_factor_in = leak;
        step();
        start = 1'b0;
        $display("job start rows=%0d leak=%h", n, leak);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, v0, k;
        int pat[5];
        tg1 = '{16'h0100, 16'h0300, 16'hFC00, 16'h0777};
        th1 = '{16'h0010, 16'hFF00, 16'h8000, 16'h0002};
        tg2 = '{16'h0400, 16'h0050, 16'h1234, 16'h0800};
        th2 = '{16'hFFF0, 16'h0001, 16'h7FFF, 16'hFFFF};
        e1_40 = '{16'h0100, 16'h00C0, 16'hFF00, 16'h0777};
        e2_40 = '{16'h0100, 16'h0050, 16'h1234, 16'h0200};
        pat = '{1, 0, 0, 1, 1};

        rst = 1'b0; start = 1'b0; num_rows = '0; leak_factor_in = '0;
        in_valid = 1'b1; in_grad_1 = 16'h1111; in_grad_2 = 16'h2222;
        in_h_1 = 16'h0001; in_h_2 = 16'h0001; inj_v2 = 1'b0;

        // Reset with in_valid high.
        step(); step();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_rdy", {31'd0, in_ready}, 0);
        chk("rst_v1", {31'd0, dp_valid_1}, 0);
        chk("rst_v2", {31'd0, dp_valid_2}, 0);
        chk("rst_leak", {16'd0, dp_leak_factor}, 0);
        chk("rst_ov", {31'd0, out_valid}, 0);
        chk("rst_o1", {16'd0, out_data_1}, 0);
        rst = 1'b1; in_valid = 1'b0;
        step();

        // Single row.
        start_job(8'd1, 16'h0080);
        chk("s_busy", {31'd0, busy}, 1);
        chk("s_leak", {16'd0, dp_leak_factor}, 32'h0080);
        chk("s_rdy", {31'd0, in_ready}, 1);
        in_valid = 1'b1; in_grad_1 = 16'h0200; in_h_1 = 16'h0100;
        in_grad_2 = 16'h0200; in_h_2 = 16'hFF00;
        step();
        in_valid = 1'b0;
        chk("s_v1", {31'd0, dp_valid_1}, 1);
        chk("s_d1", {16'd0, dp_data_1}, 32'h0200);
        chk("s_h1", {16'd0, dp_h_1}, 32'h0100);
        chk("s_v2_early", {31'd0, dp_valid_2}, 0);
        chk("s_rdy_low", {31'd0, in_ready}, 0);
        step();
        chk("s_v2", {31'd0, dp_valid_2}, 1);
        chk("s_d2", {16'd0, dp_data_2}, 32'h0200);
        chk("s_h2", {16'd0, dp_h_2}, 32'hFF00);
        chk("s_v1_off", {31'd0, dp_valid_1}, 0);
        step();
        chk("s_ov_t3", {31'd0, out_valid}, 0);
        step();
        chk("s_ov_t4", {31'd0, out_valid}, 1);
        chk("s_o1", {16'd0, out_data_1}, 32'h0200);
        chk("s_o2", {16'd0, out_data_2}, 32'h0100);
        chk("s_done_t4", {31'd0, done}, 0);
        step();
        chk("s_done_t5", {31'd0, done}, 1);
        chk("s_busy_t5", {31'd0, busy}, 1);
        step();
        chk("s_done_t6", {31'd0, done}, 0);
        chk("s_busy_t6", {31'd0, busy}, 0);
        chk("s_err", {31'd0, err}, 0);

        // Burst of four rows with in_valid held high.
        q1.delete(); q2.delete(); qc.delete(); d0 = done_cnt;
        start_job(8'd4, 16'h0040);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; drive_row(i);
            chk($sformatf("b_rdy%0d", i), {31'd0, in_ready}, 1);
            step();
        end
        chk("b_rdy_end", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        wait_idle("b_timeout");
        chk("b_rows", q1.size(), 4);
        for (int i = 0; i < 4 && i < q1.size(); i++) begin
            chk($sformatf("b_o1_%0d", i), {16'd0, q1[i]}, {16'd0, e1_40[i]});
            chk($sformatf("b_o2_%0d", i), {16'd0, q2[i]}, {16'd0, e2_40[i]});
            chk($sformatf("b_cyc_%0d", i), qc[i] - qc[0], i);
        end
        chk("b_done_cnt", done_cnt - d0, 1);
        chk("b_err", {31'd0, err}, 0);

        // Bubbles: in_valid pattern 1,0,0,1,1 for three rows.
        q1.delete(); q2.delete(); qc.delete();
        start_job(8'd3, 16'h0040);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (pat[i] != 0);
            drive_row(k < 3 ? k : 0);
            chk($sformatf("u_rdy%0d", i), {31'd0, in_ready}, 1);
            if (in_valid && in_ready) k++;
            step();
        end
        chk("u_rdy_end", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        wait_idle("u_timeout");
        chk("u_rows", q1.size(), 3);
        for (int i = 0; i < 3 && i < q1.size(); i++) begin
            chk($sformatf("u_o1_%0d", i), {16'd0, q1[i]}, {16'd0, e1_40[i]});
            chk($sformatf("u_o2_%0d", i), {16'd0, q2[i]}, {16'd0, e2_40[i]});
        end
`ifdef LRD_SEQ_PERF_EN
        chk("u_stall", {16'd0, stall_cycles}, 2);
        chk("u_job", {16'd0, job_cycles}, 11);
`endif

        // Zero-row job.
        v0 = v1_cnt; d0 = done_cnt;
        start_job(8'd0, 16'h0040);
        chk("z_done", {31'd0, done}, 1);
        chk("z_rdy", {31'd0, in_ready}, 0);
        step();
        chk("z_done_off", {31'd0, done}, 0);
        chk("z_busy", {31'd0, busy}, 0);
        chk("z_nov1", v1_cnt - v0, 0);
        chk("z_done_cnt", done_cnt - d0, 1);
`ifdef LRD_SEQ_PERF_EN
        chk("z_job", {16'd0, job_cycles}, 2);
`endif

        // Start while busy is ignored.
        q1.delete(); q2.delete(); qc.delete();
        start_job(8'd2, 16'h0080);
        in_valid = 1'b1; drive_row(0);
        start = 1'b1; num_rows = 8'd5; leak_factor_in = 16'h0010;
        step();
        start = 1'b0; drive_row(1);
        step();
        in_valid = 1'b0;
        chk("bs_leak", {16'd0, dp_leak_factor}, 32'h0080);
        wait_idle("bs_timeout");
        chk("bs_rows", q1.size(), 2);
        if (q1.size() == 2) begin
            chk("bs_o2_0", {16'd0, q2[0]}, 32'h0200);
            chk("bs_o1_1", {16'd0, q1[1]}, 32'h0180);
        end

        // Reset in the middle of DRAIN.
        q1.delete(); q2.delete(); qc.delete(); d0 = done_cnt;
        start_job(8'd2, 16'h0040);
        in_valid = 1'b1; drive_row(0);
        step();
        drive_row(1);
        step();
        in_valid = 1'b0;
        chk("r_busy_drain", {31'd0, busy}, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("r_busy", {31'd0, busy}, 0);
        chk("r_done", {31'd0, done}, 0);
        chk("r_v2", {31'd0, dp_valid_2}, 0);
        chk("r_ov", {31'd0, out_valid}, 0);
        chk("r_leak", {16'd0, dp_leak_factor}, 0);
        repeat (8) step();
        chk("r_rows", q1.size(), 0);
        chk("r_done_cnt", done_cnt - d0, 0);

        // Orphan column-2 result sets a sticky error; next start clears it.
        q1.delete(); q2.delete(); qc.delete();
        start_job(8'd1, 16'h0080);
        inj_v2 = 1'b1;
        step();
        inj_v2 = 1'b0;
        chk("e_err", {31'd0, err}, 1);
        in_valid = 1'b1; drive_row(0);
        step();
        in_valid = 1'b0;
        wait_idle("e_timeout");
        chk("e_err_sticky", {31'd0, err}, 1);
        chk("e_rows", q1.size(), 1);
        start_job(8'd0, 16'h0080);
        chk("e_err_clr", {31'd0, err}, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
